// File: rtl/i2s_sample_feeder.sv
// i2s_sample_feeder: stereo frame FIFO feeding an I2S DAC serializer.
// The serializer runs off BCLK/LRCK levels sampled in the i_CLK domain.
// Optional feature macro: I2S_FEEDER_UNDERRUN_CNT_EN enables a saturating
// 8-bit underrun frame counter on o_UNDERRUN_CNT. Without it, the port is tied to 0.
module i2s_sample_feeder #(
  parameter int DataWidth = 16,
  parameter int DepthLog2 = 3
) (
  input  logic                 i_CLK,
  input  logic                 i_NRESET,
  input  logic                 i_ENABLE,
  input  logic                 i_BCLK,
  input  logic                 i_LRCK,
  input  logic                 i_SAMPLE_VALID,
  input  logic [DataWidth-1:0] i_SAMPLE_L,
  input  logic [DataWidth-1:0] i_SAMPLE_R,
  output logic                 o_SAMPLE_READY,
  output logic                 o_DAC_DATA,
  output logic                 o_UNDERRUN,
  output logic [7:0]           o_UNDERRUN_CNT
);

  localparam int Depth = 1 << DepthLog2;
  localparam int PtrW  = DepthLog2 + 1;
  localparam int CntW  = $clog2(DataWidth + 1);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    SHIFT     = 2'd1,
    PAD       = 2'd2
  } state_e;

  logic                 bclk_q;
  logic                 lrck_q;
  logic                 bclk_fall;
  logic                 lrck_fall;
  logic                 lrck_rise;

  logic [PtrW-1:0]      wr_ptr_q;
  logic [PtrW-1:0]      rd_ptr_q;
  logic                 empty;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 underrun_evt;

  logic [DataWidth-1:0] mem_l [Depth];
  logic [DataWidth-1:0] mem_r [Depth];
  logic [DataWidth-1:0] rd_l;
  logic [DataWidth-1:0] rd_r;

  state_e               state_q;
  logic [DataWidth-1:0] shreg_q;
  logic [DataWidth-1:0] right_q;
  logic [CntW-1:0]      bit_cnt_q;
  logic                 dac_q;
  logic                 underrun_q;

  // Edges are taken between the single registered copy and the live input.
  assign bclk_fall    = bclk_q & ~i_BCLK;
  assign lrck_fall    = bclk_fall & lrck_q & ~i_LRCK;
  assign lrck_rise    = bclk_fall & ~lrck_q & i_LRCK;

  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign full         = (wr_ptr_q[DepthLog2] != rd_ptr_q[DepthLog2]) &&
                        (wr_ptr_q[DepthLog2-1:0] == rd_ptr_q[DepthLog2-1:0]);
  assign pop          = i_ENABLE & lrck_fall & ~empty;
  assign underrun_evt = i_ENABLE & lrck_fall & empty;
  // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
  assign o_SAMPLE_READY = ~full | pop;
  assign push         = i_SAMPLE_VALID & o_SAMPLE_READY;

  assign rd_l         = mem_l[rd_ptr_q[DepthLog2-1:0]];
  assign rd_r         = mem_r[rd_ptr_q[DepthLog2-1:0]];

  assign o_DAC_DATA   = dac_q;
  assign o_UNDERRUN   = underrun_q;

  // Single sampling stage for the bit clock and word select levels.
  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      bclk_q <= 1'b0;
      lrck_q <= 1'b0;
    end else begin
      bclk_q <= i_BCLK;
      lrck_q <= i_LRCK;
    end
  end

  // Frame storage; left and right words are written together.
  always_ff @(posedge i_CLK) begin
    if (push) begin
      mem_l[wr_ptr_q[DepthLog2-1:0]] <= i_SAMPLE_L;
      mem_r[wr_ptr_q[DepthLog2-1:0]] <= i_SAMPLE_R;
    end
  end

  // FIFO pointers with one extra wrap bit to tell full from empty.
  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Serializer: each BCLK fall emits the next bit of the current word, and an
  // LRCK change on the same fall reloads so its MSB goes out on the next fall.
  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      state_q    <= WAIT_SYNC;
      shreg_q    <= '0;
      right_q    <= '0;
      bit_cnt_q  <= '0;
      dac_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else if (!i_ENABLE) begin
      state_q <= WAIT_SYNC;
      dac_q   <= 1'b0;
    end else if (bclk_fall) begin
      if (state_q == SHIFT) begin
        dac_q   <= shreg_q[DataWidth-1];
        shreg_q <= shreg_q << 1;
        if (bit_cnt_q == CntW'(DataWidth - 1)) begin
          state_q <= PAD;
        end else begin
          bit_cnt_q <= bit_cnt_q + CntW'(1);
        end
      end else begin
        dac_q <= 1'b0;
      end
      if (lrck_fall) begin
        state_q   <= SHIFT;
        bit_cnt_q <= '0;
        if (!empty) begin
          shreg_q <= rd_l;
          right_q <= rd_r;
        end else begin
          shreg_q    <= '0;
          right_q    <= '0;
          underrun_q <= 1'b1;
        end
      end else if (lrck_rise && (state_q != WAIT_SYNC)) begin
        state_q   <= SHIFT;
        bit_cnt_q <= '0;
        shreg_q   <= right_q;
      end
    end
  end

`ifdef I2S_FEEDER_UNDERRUN_CNT_EN
  logic [7:0] ucnt_q;

  // Count frames sent as silence because the FIFO was empty; saturates.
  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      ucnt_q <= '0;
    end else if (underrun_evt && (ucnt_q != 8'hFF)) begin
      ucnt_q <= ucnt_q + 8'd1;
    end
  end

  assign o_UNDERRUN_CNT = ucnt_q;
`else
  assign o_UNDERRUN_CNT = '0;
`endif

endmodule

// File: tb/tb_i2s_sample_feeder.sv
// Bench for i2s_sample_feeder: drives BCLK/LRCK slots and frames, and
// predicts every DACDAT bit from a frame queue and an I2S slot model.
module tb_i2s_sample_feeder;

  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          nrst;
  logic          en;
  logic          bclk;
  logic          lrck;
  logic          valid;
  logic [DW-1:0] sl;
  logic [DW-1:0] sr;
  logic          ready;
  logic          dac;
  logic          und;
  logic [7:0]    ucnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] q_l[$];
  logic [DW-1:0] q_r[$];
  logic [DW-1:0] m_slot;
  logic [DW-1:0] m_held;
  int            m_n;
  bit            m_sync;
  bit            m_prev;
  bit            m_und;
  int            m_cnt;
  logic [63:0]   obs;

  always #5 clk = ~clk;

  i2s_sample_feeder #(
    .DataWidth(DW),
    .DepthLog2(3)
  ) dut (
    .i_CLK         (clk),
    .i_NRESET      (nrst),
    .i_ENABLE      (en),
    .i_BCLK        (bclk),
    .i_LRCK        (lrck),
    .i_SAMPLE_VALID(valid),
    .i_SAMPLE_L    (sl),
    .i_SAMPLE_R    (sr),
    .o_SAMPLE_READY(ready),
    .o_DAC_DATA    (dac),
    .o_UNDERRUN    (und),
    .o_UNDERRUN_CNT(ucnt)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, got=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    q_l.delete();
    q_r.delete();
    m_slot = '0;
    m_held = '0;
    m_n    = 0;
    m_sync = 1'b0;
    m_und  = 1'b0;
    m_cnt  = 0;
    m_prev = lrck;
  endtask

  // One BCLK fall: bit k after a word load carries word bit DW-k (k=1..DW),
  // anything past the word is zero; an LRCK change starts a new slot.
  task automatic model_fall(input bit new_lr, output logic exp_bit);
    if (!en) begin
      exp_bit = 1'b0;
      m_sync  = 1'b0;
      m_prev  = new_lr;
      return;
    end
    m_n = m_n + 1;
    exp_bit = (m_sync && m_n >= 1 && m_n <= DW) ? m_slot[DW-m_n] : 1'b0;
    if (m_prev && !new_lr) begin
      m_sync = 1'b1;
      m_n    = 0;
      if (q_l.size() > 0) begin
        m_slot = q_l.pop_front();
        m_held = q_r.pop_front();
      end else begin
        m_slot = '0;
        m_held = '0;
        m_und  = 1'b1;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end
    end else if (!m_prev && new_lr && m_sync) begin
      m_slot = m_held;
      m_n    = 0;
    end
    m_prev = new_lr;
  endtask

  task automatic do_reset(input logic lr);
    @(negedge clk);
    nrst  = 1'b0;
    valid = 1'b0;
    bclk  = 1'b1;
    lrck  = lr;
    en    = 1'b1;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  // Push a frame while BCLK is stable (no pop possible this cycle).
  task automatic push(input logic [DW-1:0] pl, input logic [DW-1:0] pr);
    bit exp_rdy;
    exp_rdy = (q_l.size() < DEPTH);
    valid = 1'b1;
    sl    = pl;
    sr    = pr;
    #1;
    total++;
    if (ready !== exp_rdy) begin
      bad++;
      $display("FAIL push_ready t=%0t got=%b exp=%b", $time, ready, exp_rdy);
    end
    if (exp_rdy) begin
      q_l.push_back(pl);
      q_r.push_back(pr);
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
    @(negedge clk);
  endtask

  // One BCLK period: fall (with new LRCK), 2 cycles low, 2 cycles high.
  task automatic tick(input logic new_lr, input bit do_push,
                      input logic [DW-1:0] pl, input logic [DW-1:0] pr);
    logic exp_bit;
    bit   exp_pop;
    bit   exp_rdy;
    exp_pop = en && m_prev && !new_lr && (q_l.size() > 0);
    exp_rdy = (q_l.size() < DEPTH) || exp_pop;
    bclk  = 1'b0;
    lrck  = new_lr;
    valid = do_push;
    sl    = pl;
    sr    = pr;
    #1;
    if (do_push) begin
      total++;
      if (ready !== exp_rdy) begin
        bad++;
        $display("FAIL tick_ready t=%0t got=%b exp=%b", $time, ready, exp_rdy);
      end
    end
    model_fall(new_lr, exp_bit);
    if (do_push && exp_rdy) begin
      q_l.push_back(pl);
      q_r.push_back(pr);
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
    total++;
    if (dac !== exp_bit) begin
      bad++;
      $display("FAIL dac_bit t=%0t got=%b exp=%b", $time, dac, exp_bit);
    end
    obs = {obs[62:0], dac};
    @(negedge clk);
    @(negedge clk);
    bclk = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_frames(input int nf, input int bpc);
    for (int f = 0; f < nf; f++) begin
      for (int b = 0; b < bpc; b++) tick(1'b0, 1'b0, '0, '0);
      for (int b = 0; b < bpc; b++) tick(1'b1, 1'b0, '0, '0);
    end
  endtask

  task automatic check_flags(input string tag);
    logic [7:0] exp_c;
`ifdef I2S_FEEDER_UNDERRUN_CNT_EN
    exp_c = 8'(m_cnt);
`else
    exp_c = 8'd0;
`endif
    total++;
    if (und !== m_und) begin
      bad++;
      $display("FAIL %s_underrun got=%b exp=%b", tag, und, m_und);
    end
    total++;
    if (ucnt !== exp_c) begin
      bad++;
      $display("FAIL %s_ucnt got=%0d exp=%0d", tag, ucnt, exp_c);
    end
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    total++;
    if (dac !== 1'b0) begin bad++; $display("FAIL reset_dac got=%b exp=0", dac); end
    total++;
    if (und !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b exp=0", und); end
    total++;
    if (ucnt !== 8'd0) begin bad++; $display("FAIL reset_ucnt got=%0d exp=0", ucnt); end
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
  endtask

  task automatic test_known_vector();
    do_reset(1'b1);
    push(16'hA5F0, 16'h0F0F);
    run_frames(1, 16);
    tick(1'b0, 1'b0, '0, '0);
    total++;
    if (obs[31:0] !== 32'hA5F00F0F) begin
      bad++;
      $display("FAIL known_vector got=%h exp=a5f00f0f", obs[31:0]);
    end
    check_flags("known");
  endtask

  task automatic test_fill();
    do_reset(1'b1);
    for (int i = 0; i < DEPTH; i++) push(DW'($urandom), DW'($urandom));
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL fill_ready_low got=%b exp=0", ready); end
    push(16'hDEAD, 16'hBEEF);
    run_frames(DEPTH, 16);
    tick(1'b0, 1'b0, '0, '0);
    check_flags("fill");
  endtask

  task automatic test_coincident();
    do_reset(1'b1);
    for (int i = 0; i < DEPTH; i++) push(DW'($urandom), DW'($urandom));
    tick(1'b0, 1'b1, DW'($urandom), DW'($urandom));
    total++;
    if (ready !== (q_l.size() < DEPTH)) begin
      bad++;
      $display("FAIL coinc_ready_after got=%b exp=%b", ready, (q_l.size() < DEPTH));
    end
    for (int b = 1; b < 16; b++) tick(1'b0, 1'b0, '0, '0);
    for (int b = 0; b < 16; b++) tick(1'b1, 1'b0, '0, '0);
    run_frames(DEPTH, 16);
    tick(1'b0, 1'b0, '0, '0);
    check_flags("coinc");
  endtask

  task automatic test_underrun();
    do_reset(1'b1);
    run_frames(3, 16);
    total++;
    if (und !== 1'b1) begin bad++; $display("FAIL underrun_flag got=%b exp=1", und); end
    total++;
`ifdef I2S_FEEDER_UNDERRUN_CNT_EN
    if (ucnt !== 8'd3) begin bad++; $display("FAIL underrun_cnt got=%0d exp=3", ucnt); end
`else
    if (ucnt !== 8'd0) begin bad++; $display("FAIL underrun_cnt got=%0d exp=0", ucnt); end
`endif
  endtask

  task automatic test_reset_midword();
    do_reset(1'b1);
    run_frames(1, 16);
    push(16'hFFFF, 16'hFFFF);
    for (int b = 0; b < 6; b++) tick(1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    total++;
    if (dac !== 1'b0) begin bad++; $display("FAIL midrst_dac got=%b exp=0", dac); end
    total++;
    if (und !== 1'b0) begin bad++; $display("FAIL midrst_underrun got=%b exp=0", und); end
    total++;
    if (ucnt !== 8'd0) begin bad++; $display("FAIL midrst_ucnt got=%0d exp=0", ucnt); end
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", ready); end
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    model_reset();
    @(negedge clk);
    push(DW'($urandom), DW'($urandom));
    for (int b = 0; b < 10; b++) tick(1'b0, 1'b0, '0, '0);
    for (int b = 0; b < 16; b++) tick(1'b1, 1'b0, '0, '0);
    run_frames(1, 16);
    tick(1'b0, 1'b0, '0, '0);
    check_flags("midrst");
  endtask

  task automatic test_enable();
    do_reset(1'b1);
    push(16'hFFFF, 16'hFFFF);
    push(DW'($urandom), DW'($urandom));
    for (int b = 0; b < 5; b++) tick(1'b0, 1'b0, '0, '0);
    en     = 1'b0;
    m_sync = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (dac !== 1'b0) begin bad++; $display("FAIL enable_off_dac got=%b exp=0", dac); end
    @(negedge clk);
    for (int b = 0; b < 3; b++) tick(1'b0, 1'b0, '0, '0);
    for (int b = 0; b < 8; b++) tick(1'b1, 1'b0, '0, '0);
    en = 1'b1;
    run_frames(2, 16);
    tick(1'b0, 1'b0, '0, '0);
    check_flags("enable");
  endtask

  task automatic test_random();
    int bpc;
    do_reset(1'b1);
    for (int f = 0; f < 20; f++) begin
      for (int k = $urandom_range(0, 2); k > 0; k--) push(DW'($urandom), DW'($urandom));
      case ($urandom_range(0, 2))
        0:       bpc = 12;
        1:       bpc = 16;
        default: bpc = 20;
      endcase
      run_frames(1, bpc);
    end
    tick(1'b0, 1'b0, '0, '0);
    check_flags("random");
  endtask

  initial begin
    nrst  = 1'b0;
    en    = 1'b1;
    bclk  = 1'b1;
    lrck  = 1'b1;
    valid = 1'b0;
    sl    = '0;
    sr    = '0;
    obs   = '0;
    test_reset();
    test_known_vector();
    test_fill();
    test_coincident();
    test_underrun();
    test_reset_midword();
    test_enable();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_sample_feeder.md
I2S_SAMPLE_FEEDER -- requirements
Module: i2s_sample_feeder

Interface
REQ-001 SHALL have parameter DataWidth, default 16, meaning bits per channel sample.
REQ-002 SHALL have parameter DepthLog2, default 3, meaning FIFO depth 2**DepthLog2 stereo frames.
REQ-003 SHALL have port i_CLK  input  1  system clock; the only clock.
REQ-004 SHALL have port i_NRESET  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_ENABLE  input  1  when low: FIFO holds, serializer frozen, o_DAC_DATA driven 0.
REQ-006 SHALL have port i_BCLK  input  1  bit clock level, synchronous to i_CLK, high and low phases each >= 2 i_CLK cycles.
REQ-007 SHALL have port i_LRCK  input  1  word select, synchronous to i_CLK, changes only with i_BCLK falling; 0 = left.
REQ-008 SHALL have port i_SAMPLE_VALID  input  1  write request for one stereo frame.
REQ-009 SHALL have port i_SAMPLE_L  input  DataWidth  left sample, two's complement.
REQ-010 SHALL have port i_SAMPLE_R  input  DataWidth  right sample, two's complement.
REQ-011 SHALL have port o_SAMPLE_READY  output  1  high when FIFO not full.
REQ-012 SHALL have port o_DAC_DATA  output  1  I2S serial data (DACDAT).
REQ-013 SHALL have port o_UNDERRUN  output  1  sticky flag, set when a frame is needed and FIFO is empty.
REQ-014 SHALL have port o_UNDERRUN_CNT  output  8  underrun count (see Configuration).

Function
REQ-015 SHALL register i_BCLK and i_LRCK once; BCLK fall = previous 1 and current 0, evaluated in i_CLK domain.
REQ-016 SHALL accept a frame on any cycle with i_SAMPLE_VALID and o_SAMPLE_READY both high; L and R stored together.
REQ-017 SHALL ignore i_SAMPLE_VALID while o_SAMPLE_READY is low; the frame is dropped with no state change.
REQ-018 SHALL keep read/write pointers DepthLog2+1 bits wide and wrap modulo 2**(DepthLog2+1); full = MSBs differ and LSBs equal, empty = pointers equal.
REQ-019 SHALL allow push and pop in the same cycle, including when full; occupancy is unchanged and o_SAMPLE_READY does not drop.
REQ-020 SHALL implement serializer states WAIT_SYNC, SHIFT, PAD.
REQ-021 WAIT_SYNC after reset/enable: o_DAC_DATA=0; on the first BCLK fall where registered LRCK changes 1->0, go to SHIFT for left channel.
REQ-022 On a BCLK fall with LRCK change 1->0: pop one frame (if non-empty) and load left word into the shift register; on change 0->1 load the retained right word.
REQ-023 SHALL output the MSB on the BCLK fall following the load (one-bit I2S delay) and one bit per subsequent fall, MSB first.
REQ-024 After DataWidth bits SHALL enter PAD and drive 0 until the next LRCK change, which reloads per REQ-022.
REQ-025 o_DAC_DATA SHALL update exactly 1 i_CLK cycle after the cycle in which the BCLK fall is detected.
REQ-026 If the FIFO is empty at a 1->0 LRCK change, SHALL transmit zero for both channels of that frame and set o_UNDERRUN.
REQ-027 An LRCK change before DataWidth bits are sent SHALL truncate the word and reload; no error flag.
REQ-028 Deasserting i_ENABLE mid-word SHALL return to WAIT_SYNC; FIFO contents are retained.

Reset
REQ-029 On i_NRESET low, immediately: pointers 0, state WAIT_SYNC, shift register 0, o_DAC_DATA 0, o_UNDERRUN 0, o_UNDERRUN_CNT 0, o_SAMPLE_READY 1.
REQ-030 Reset mid-word SHALL abandon the word; after release, serialization restarts at the next left-channel boundary.
REQ-031 o_UNDERRUN SHALL be cleared only by reset.

Configuration
REQ-032 Macro I2S_FEEDER_UNDERRUN_CNT_EN defined: o_UNDERRUN_CNT increments by 1 per underrun frame, saturating at 255.
REQ-033 Macro undefined: o_UNDERRUN_CNT tied to 0, no counter logic; all other behaviour identical.

Verification
REQ-034 Push L=16'hA5F0, R=16'h0F0F into empty FIFO, run BCLK/LRCK -> DACDAT bits 1010010111110000 starting on 2nd BCLK fall after LRCK falls, then 0000111100001111 after LRCK rises.
REQ-035 Push 8 frames without popping (DepthLog2=3) -> o_SAMPLE_READY low after 8th accept; 9th valid dropped; order preserved on readout.
REQ-036 FIFO full with push coincident with LRCK 1->0 pop -> both occur, o_SAMPLE_READY stays high one cycle later only if occupancy < 8, no frame lost.
REQ-037 No frames pushed, 3 LRCK periods -> DACDAT constant 0, o_UNDERRUN=1, o_UNDERRUN_CNT=3 with macro, 0 without.
REQ-038 Assert i_NRESET low mid-shift of 16'hFFFF -> o_DAC_DATA 0 same cycle, all outputs at REQ-029 values, next output starts at next left boundary.
